// File: rtl/opb_regbank_pkg.sv
// Shared types and helpers for the OPB register bank: slave FSM states,
// byte-lane masking and the location of the commit word.
package opb_regbank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } opb_state_t;

    localparam int OPB_WORD_BYTES = 4;

    // be[j] enables user bits 8j+7:8j (be[3] is the OPB BE[0] lane, bits 31:24).
    function automatic logic [31:0] lane_mask(input logic [OPB_WORD_BYTES-1:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Commit word sits directly after the control and status blocks.
    function automatic logic [31:0] commit_offset(input int unsigned num_regs);
        return 32'(2 * num_regs);
    endfunction

endpackage

// File: rtl/opb_regbank_word.sv
// One 32-bit register with byte-enable write, parametrised reset value and a
// one-cycle strobe that is high in the cycle after a write.
module opb_regbank_word
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [OPB_WORD_BYTES-1:0] be,
    input  logic [31:0]               wdata,
    output logic [31:0]               q,
    output logic                      strobe
);

    logic [31:0] mask;

    assign mask = lane_mask(be);

    // Strobe follows wr_en even with no byte enabled: the access still happened.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= RESET_VAL;
            strobe <= 1'b0;
        end else begin
            strobe <= wr_en;
            if (wr_en) begin
                q <= (q & ~mask) | (wdata & mask);
            end
        end
    end

endmodule

// File: rtl/opb_register_bank.sv
// OPB slave with C_NUM_REGS control and C_NUM_REGS status words.
// Define REGBANK_SHADOW_EN to stage control writes in shadows until a commit.
module opb_register_bank
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h010B_0000,
    parameter logic [31:0] C_HIGHADDR   = 32'h010B_00FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter int          C_NUM_REGS   = 8,
    parameter logic [31:0] C_RESET_VAL  = 32'h0
) (
    input  logic                        OPB_Clk,
    input  logic                        OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1]     OPB_ABus,
    input  logic [0:C_OPB_DWIDTH/8-1]   OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1]     OPB_DBus,
    input  logic                        OPB_RNW,
    input  logic                        OPB_select,
    input  logic                        OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1]     Sl_DBus,
    output logic                        Sl_xferAck,
    output logic                        Sl_errAck,
    output logic                        Sl_retry,
    output logic                        Sl_toutSup,
    output logic [32*C_NUM_REGS-1:0]    user_data_out,
    output logic [C_NUM_REGS-1:0]       user_wr_strobe,
    input  logic [32*C_NUM_REGS-1:0]    user_status_in,
    output opb_state_t                  dbg_state
);

    localparam logic [31:0] NREG = 32'(C_NUM_REGS);

    opb_state_t                state;
    logic [31:0]               addr;
    logic [31:0]               offset;
    logic [31:0]               word_idx;
    logic [31:0]               wdata;
    logic [OPB_WORD_BYTES-1:0] be_le;
    logic                      hit;
    logic                      wr_start;
    logic [31:0]               rd_mux;
    logic [31:0]               rd_data;
    logic [C_NUM_REGS-1:0]     ctrl_we;
    logic [31:0]               ctrl_view [C_NUM_REGS];

    // Big-endian OPB vectors land on little-endian user bits positionally.
    assign addr     = OPB_ABus;
    assign wdata    = OPB_DBus;
    assign be_le    = OPB_BE;
    assign offset   = addr - C_BASEADDR;
    assign word_idx = offset >> 2;
    assign hit      = OPB_select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign wr_start = (state == ST_IDLE) && hit && !OPB_RNW;

    assign Sl_errAck  = 1'b0;
    assign Sl_retry   = 1'b0;
    assign Sl_toutSup = 1'b0;
    assign Sl_DBus    = rd_data;
    assign dbg_state  = state;

`ifdef REGBANK_SHADOW_EN
    localparam logic [31:0] COMMIT_IDX = commit_offset(C_NUM_REGS);
    logic commit;

    assign commit = wr_start && (word_idx == COMMIT_IDX) && wdata[0];
`endif

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_reg
        assign ctrl_we[i] = wr_start && (word_idx == 32'(i));
`ifdef REGBANK_SHADOW_EN
        logic [31:0] shadow_q;

        opb_regbank_word #(.RESET_VAL(C_RESET_VAL)) u_shadow (
            .clk    (OPB_Clk),
            .rst_n  (OPB_Rst_n),
            .wr_en  (ctrl_we[i]),
            .be     (be_le),
            .wdata  (wdata),
            .q      (shadow_q),
            .strobe ()
        );

        opb_regbank_word #(.RESET_VAL(C_RESET_VAL)) u_out (
            .clk    (OPB_Clk),
            .rst_n  (OPB_Rst_n),
            .wr_en  (commit),
            .be     ({OPB_WORD_BYTES{1'b1}}),
            .wdata  (shadow_q),
            .q      (user_data_out[32*i +: 32]),
            .strobe (user_wr_strobe[i])
        );

        assign ctrl_view[i] = shadow_q;
`else
        opb_regbank_word #(.RESET_VAL(C_RESET_VAL)) u_out (
            .clk    (OPB_Clk),
            .rst_n  (OPB_Rst_n),
            .wr_en  (ctrl_we[i]),
            .be     (be_le),
            .wdata  (wdata),
            .q      (user_data_out[32*i +: 32]),
            .strobe (user_wr_strobe[i])
        );

        assign ctrl_view[i] = user_data_out[32*i +: 32];
`endif
    end

    // Unmapped in-window words (including the commit word) read as zero.
    always_comb begin
        rd_mux = 32'h0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (word_idx == 32'(i)) begin
                rd_mux = ctrl_view[i];
            end
            if (word_idx == NREG + 32'(i)) begin
                rd_mux = user_status_in[32*i +: 32];
            end
        end
    end

    // Handshake: a transfer starts when OPB_select is sampled high in IDLE with
    // an in-window address; Sl_xferAck is high for exactly the following cycle
    // and Sl_DBus carries read data only then. HOLD waits for the master to drop
    // select (or flag a sequential access) so one request yields one ack.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state      <= ST_IDLE;
            Sl_xferAck <= 1'b0;
            rd_data    <= 32'h0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (hit) begin
                        state      <= ST_ACK;
                        Sl_xferAck <= 1'b1;
                        rd_data    <= OPB_RNW ? rd_mux : 32'h0;
                    end
                end
                ST_ACK: begin
                    state      <= ST_HOLD;
                    Sl_xferAck <= 1'b0;
                    rd_data    <= 32'h0;
                end
                ST_HOLD: begin
                    if (!OPB_select || OPB_seqAddr) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    Sl_xferAck <= 1'b0;
                    rd_data    <= 32'h0;
                end
            endcase
        end
    end

endmodule

// File: doc/opb_register_bank.md
# opb_register_bank

Parametrised OPB slave exposing C_NUM_REGS 32-bit PPC-writable control registers and C_NUM_REGS read-only status registers to user logic on a single clock. It is the multi-register successor of the single-word ppc2simulink register and sits on the XPS ROACH OPB bus between the PowerPC and the channeliser/packetiser fabric. Unlike that single word, it adds byte-enable writes, full readback, per-register update strobes and sampled status inputs.

## Interface
- C_BASEADDR, 32'h010B0000, first byte address of the window
- C_HIGHADDR, 32'h010B00FF, last byte address of the window
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width (only 32 supported)
- C_NUM_REGS, 8, control/status register count, 1..16; 8*C_NUM_REGS+4 must be ≤ window size
- C_RESET_VAL, 32'h0, reset value of every control register

- OPB_Clk  in  1  sole clock
- OPB_Rst_n  in  1  asynchronous active-low reset
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables, BE[0] ↔ DBus[0:7]
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read
- OPB_select  in  1  transfer request
- OPB_seqAddr  in  1  sequential burst hint
- Sl_DBus  out  [0:31]  read data, zero unless Sl_xferAck
- Sl_xferAck  out  1  transfer acknowledge
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0
- user_data_out  out  [32*C_NUM_REGS-1:0]  control registers, reg i at [32i+31:32i]
- user_wr_strobe  out  [C_NUM_REGS-1:0]  one-cycle pulse when reg i's output updates
- user_status_in  in  [32*C_NUM_REGS-1:0]  status words

## Operation
- Bit mapping: DBus[k] ↔ user bit 31-k; BE[0] → bits 31:24 … BE[3] → bits 7:0.
- Hit = OPB_select & C_BASEADDR ≤ ABus ≤ C_HIGHADDR; word index w = (ABus-C_BASEADDR)>>2.
- Map: w in 0..N-1 control (R/W); w in N..2N-1 status (RO, writes ignored); w = 2N commit (macro only); other in-window words read 0, writes ignored, still acked.
- FSM: IDLE → ACK on hit; ACK → HOLD unconditionally; HOLD → IDLE when !OPB_select or OPB_seqAddr, else stay.
- Write on the IDLE→ACK edge: enabled bytes only; strobe bit i high in ACK cycle for control writes even if BE=0000.
- Read: data muxed and registered on the IDLE→ACK edge; status sampled at that same edge.
- Sl_DBus forced to 0 in all states but ACK (wired-OR bus).

## Timing
- Reset: user_data_out = C_RESET_VAL replicated, strobes 0, Sl_* 0, FSM IDLE; takes effect immediately, aborting any transfer (no ack issued).
- Latency: select sampled high at edge k → Sl_xferAck high for exactly cycle k..k+1; user_data_out valid from edge k.
- Minimum spacing: one transfer per 3 cycles; HOLD prevents double-ack while master drops select.
- Status change on the sampling edge: pre-edge value returned.
- Addresses outside window: no ack, bus stays 0 (master times out).

## Configuration
- REGBANK_SHADOW_EN defined: control writes land in shadow registers; reads return shadow; writing commit word with DBus[31]=1 (user bit 0) copies all shadows to user_data_out at the ACK edge and pulses all user_wr_strobe bits together; no per-write strobes.
- Undefined: writes go straight to user_data_out as above; commit word reads 0, writes ignored.

## Structure
- Package opb_regbank_pkg: FSM state enum (IDLE, ACK, HOLD), OPB_WORD_BYTES = 4, byte-lane-to-bit-range function, commit offset helper.
- Sub-module opb_regbank_word: one 32-bit register with byte-enable write, reset value and strobe, instantiated per control (and shadow) register.

## Test plan
- Reset released, read w=0 → Sl_DBus = C_RESET_VAL on ack cycle, 0 otherwise; strobes 0.
- Write 0xDEADBEEF BE=1111 to w=2 → user_data_out[95:64]=0xDEADBEEF, user_wr_strobe=8'b00000100 for one cycle, ack one cycle after select.
- Write 0x11223344 BE=0101 over 0xDEADBEEF at w=2 → reads 0xDE22BE44.
- Status w=N+1 with user_status_in word1 = 0xA5A5A5A5 → read 0xA5A5A5A5; write there leaves it and all outputs unchanged.
- Select held 4 cycles, seqAddr=0 → exactly one xferAck; reset asserted in ACK → xferAck falls immediately, no write.
- REGBANK_SHADOW_EN: write 0x5 to w=0 → output unchanged; commit with bit 0 set → output 0x5, all strobes pulse once.
